// File: rtl/apb_vgachargen_pkg.sv
// ============================================================================
//  Module      : apb_vgachargen_pkg
//  Description : Register map, bit positions and FSM encoding shared by the
//                APB character-generator control block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_vgachargen_pkg;

    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_CURSOR = 2'd2;
    localparam logic [1:0] c_REG_DATA   = 2'd3;

    localparam int c_CTRL_EN      = 0;
    localparam int c_CTRL_AUTOINC = 1;
    localparam int c_CTRL_CLR     = 2;

    localparam int c_STAT_BUSY  = 0;
    localparam int c_STAT_FULL  = 1;
    localparam int c_STAT_EMPTY = 2;
    localparam int c_STAT_LVL   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fsm_e;

    localparam logic [7:0] SPACE_CHAR = 8'h20;

endpackage

`default_nettype wire

// File: rtl/chargen_wr_fifo.sv
// ============================================================================
//  Module      : chargen_wr_fifo
//  Description : Synchronous FIFO buffering char/attribute write entries.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chargen_wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_level = r_wptr - r_rptr;
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    assign o_empty = (r_wptr == r_rptr);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/apb_vgachargen_ctrl.sv
// ============================================================================
//  Module      : apb_vgachargen_ctrl
//  Description : APB slave that buffers character writes, auto-advances the
//                cursor and runs a hardware clear-screen engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_vgachargen_ctrl
    import apb_vgachargen_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int COLS           = 80,
    parameter int ROWS           = 60,
    parameter int CHAR_W         = 8,
    parameter int ATTR_W         = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [APB_ADDR_WIDTH-1:0]             apb_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]             apb_pwdata_i,
    input  logic                                  apb_pwrite_i,
    input  logic                                  apb_psel_i,
    input  logic                                  apb_penable_i,
    output logic [APB_DATA_WIDTH-1:0]             apb_prdata_o,
    output logic                                  apb_pready_o,
    output logic                                  apb_pslverr_o,
    output logic                                  mem_valid_o,
    input  logic                                  mem_ready_i,
    output logic [$clog2(COLS*ROWS)-1:0]          mem_addr_o,
    output logic [CHAR_W-1:0]                     mem_char_o,
    output logic [ATTR_W-1:0]                     mem_attr_o,
    output logic                                  display_en_o
);

    localparam int N       = COLS * ROWS;
    localparam int POS_W   = $clog2(N);
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = POS_W + CHAR_W + ATTR_W;

    localparam logic [POS_W-1:0]          c_LAST   = POS_W'(N - 1);
    localparam logic [APB_DATA_WIDTH-1:0] c_N_DATA = APB_DATA_WIDTH'(N);

    fsm_e                r_state;
    logic                r_en;
    logic                r_autoinc;
    logic [POS_W-1:0]    r_cursor;
    logic [POS_W-1:0]    r_clr_cnt;

    logic                w_access;
    logic                w_addr_ok;
    logic [1:0]          w_reg;
    logic                w_err;
    logic                w_data_wr;
    logic                w_stall;
    logic                w_pready;
    logic                w_commit;
    logic                w_wr_ctrl;
    logic                w_wr_cursor;
    logic                w_push;
    logic                w_pop;
    logic                w_clr_mode;
    logic                w_mem_valid;
    logic                w_hs;
    logic                w_full;
    logic                w_empty;
    logic [LVL_W-1:0]    w_level;
    logic [ENTRY_W-1:0]  w_head;
    logic [POS_W-1:0]    w_cursor_next;
    logic [APB_DATA_WIDTH-1:0] w_rdata;
    logic                w_unused;

    assign w_unused  = ^apb_paddr_i[1:0];

    assign w_access  = apb_psel_i & apb_penable_i;
    assign w_addr_ok = (apb_paddr_i[APB_ADDR_WIDTH-1:4] == '0);
    assign w_reg     = apb_paddr_i[3:2];

    always_comb begin
        w_err = 1'b0;
        if (!w_addr_ok) begin
            w_err = 1'b1;
        end else begin
            case (w_reg)
                c_REG_STATUS: w_err = apb_pwrite_i;
                c_REG_DATA:   w_err = ~apb_pwrite_i;
                c_REG_CURSOR: w_err = apb_pwrite_i & (apb_pwdata_i >= c_N_DATA);
                default:      w_err = 1'b0;
            endcase
        end
    end

    // A DATA write waits while the FIFO is full (even if it pops this cycle)
    // or while a drain/clear is in progress, so it lands after the clear.
    assign w_data_wr   = w_access & apb_pwrite_i & w_addr_ok & (w_reg == c_REG_DATA);
    assign w_stall     = w_data_wr & (w_full | (r_state != IDLE));
    assign w_pready    = w_access & ~w_stall;
    assign w_commit    = w_pready & ~w_err;
    assign w_wr_ctrl   = w_commit & apb_pwrite_i & (w_reg == c_REG_CTRL);
    assign w_wr_cursor = w_commit & apb_pwrite_i & (w_reg == c_REG_CURSOR);
    assign w_push      = w_commit & apb_pwrite_i & (w_reg == c_REG_DATA);

    assign w_clr_mode  = (r_state == CLEAR);
    assign w_mem_valid = r_en & (w_clr_mode | ~w_empty);
    assign w_hs        = w_mem_valid & mem_ready_i;
    assign w_pop       = w_hs & ~w_clr_mode;

    assign w_cursor_next = (r_cursor == c_LAST) ? '0 : r_cursor + POS_W'(1);

    chargen_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_data  ({r_cursor, apb_pwdata_i[CHAR_W-1:0], apb_pwdata_i[CHAR_W +: ATTR_W]}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        mem_addr_o = '0;
        mem_char_o = '0;
        mem_attr_o = '0;
        if (w_mem_valid) begin
            if (w_clr_mode) begin
                mem_addr_o = r_clr_cnt;
                mem_char_o = CHAR_W'(SPACE_CHAR);
            end else begin
                mem_addr_o = w_head[ENTRY_W-1:CHAR_W+ATTR_W];
                mem_char_o = w_head[CHAR_W+ATTR_W-1:ATTR_W];
                mem_attr_o = w_head[ATTR_W-1:0];
            end
        end
    end

    assign mem_valid_o  = w_mem_valid;
    assign display_en_o = r_en;

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            c_REG_CTRL: begin
                w_rdata[c_CTRL_EN]      = r_en;
                w_rdata[c_CTRL_AUTOINC] = r_autoinc;
            end
            c_REG_STATUS: begin
                w_rdata[c_STAT_BUSY]           = (r_state != IDLE);
                w_rdata[c_STAT_FULL]           = w_full;
                w_rdata[c_STAT_EMPTY]          = w_empty;
                w_rdata[c_STAT_LVL +: LVL_W]   = w_level;
            end
            c_REG_CURSOR: w_rdata[POS_W-1:0] = r_cursor;
            default:      w_rdata = '0;
        endcase
    end

    assign apb_pready_o  = w_pready;
    assign apb_pslverr_o = w_pready & w_err;
    assign apb_prdata_o  = (w_pready & ~apb_pwrite_i & ~w_err) ? w_rdata : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_en      <= 1'b0;
            r_autoinc <= 1'b0;
            r_cursor  <= '0;
            r_clr_cnt <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en      <= apb_pwdata_i[c_CTRL_EN];
                r_autoinc <= apb_pwdata_i[c_CTRL_AUTOINC];
            end
            if (w_wr_cursor) r_cursor <= apb_pwdata_i[POS_W-1:0];
            if (w_push && r_autoinc) r_cursor <= w_cursor_next;

            case (r_state)
                IDLE: begin
                    if (w_wr_ctrl && apb_pwdata_i[c_CTRL_CLR]) begin
                        r_state  <= DRAIN;
                        r_cursor <= '0;
                    end
                end
                DRAIN: begin
                    if (r_en && w_empty) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (w_hs) begin
                        if (r_clr_cnt == c_LAST) r_state <= IDLE;
                        else                     r_clr_cnt <= r_clr_cnt + POS_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
